synth_param_bank: RTL and testbench

Parametrised, clocked parameter store for the synthesizer front panel. Holds a NUM_SLOTS × NUM_PARAMS grid of DATA_W-bit voice/envelope parameters and commits one entry per debounced press of the load key, addressed by slot/parameter selectors. It provides per-parameter width masking, reset defaults, registered readback of the selected entry and an update strobe for downstream oscillator/ADSR blocks. It sits between the switch/key inputs and every sound-generation module.

---
 rtl/synth_param_bank_if.sv | 30 +++
 rtl/synth_param_bank.sv | 142 ++++++++++++++
 tb/tb_synth_param_bank.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_param_bank_if.sv
// Front-panel bus for synth_param_bank: key, selectors and write data in;
// the stored parameter grid, readback and the update/error strobes out.
interface synth_param_bank_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int NUM_PARAMS = 16,
  parameter int DATA_W     = 11,
  parameter int SLOT_W     = 3,
  parameter int PARAM_W    = 4
);
  logic                                 load;
  logic [SLOT_W-1:0]                    sel_slot;
  logic [PARAM_W-1:0]                   sel_param;
  logic [DATA_W-1:0]                    wr_data;
  logic [NUM_SLOTS*NUM_PARAMS*DATA_W-1:0] param_bus;
  logic [DATA_W-1:0]                    rd_data;
  logic                                 upd_valid;
  logic [SLOT_W-1:0]                    upd_slot;
  logic [PARAM_W-1:0]                   upd_param;
  logic                                 addr_err;

  modport master (
    output load, sel_slot, sel_param, wr_data,
    input  param_bus, rd_data, upd_valid, upd_slot, upd_param, addr_err
  );

  modport slave (
    input  load, sel_slot, sel_param, wr_data,
    output param_bus, rd_data, upd_valid, upd_slot, upd_param, addr_err
  );
endinterface

// File: rtl/synth_param_bank.sv
// Parameter store committing one masked entry per load-key press.
// Define SYNTH_PARAM_BANK_DEBOUNCE_EN to require DEBOUNCE_CYCLES of stable key before committing.
module synth_param_bank #(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_PARAMS      = 16,
  parameter int DATA_W          = 11,
  parameter int SLOT_W          = 3,
  parameter int PARAM_W         = 4,
  parameter logic [NUM_PARAMS*DATA_W-1:0]           PARAM_MASK   = '1,
  parameter logic [NUM_SLOTS*NUM_PARAMS*DATA_W-1:0] RESET_VALUES = '0,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  synth_param_bank_if.slave bus
);

  localparam int BANK_W = NUM_SLOTS * NUM_PARAMS * DATA_W;
  localparam logic [BANK_W-1:0] FULL_MASK = {NUM_SLOTS{PARAM_MASK}};

  if (DEBOUNCE_CYCLES < 1 || NUM_SLOTS < 1 || NUM_PARAMS < 1 ||
      (2 ** SLOT_W) < NUM_SLOTS || (2 ** PARAM_W) < NUM_PARAMS) begin : g_bad_cfg
    $error("synth_param_bank: invalid parameter combination");
  end

`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, WAIT_RELEASE} state_t;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_next;
`else
  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_RELEASE} state_t;
`endif

  state_t              state, state_next;
  logic                sync_ff, load_s;
  logic                commit;
  logic [BANK_W-1:0]   bank;
  logic [DATA_W-1:0]   rd_q;
  logic                upd_valid_q, addr_err_q;
  logic [SLOT_W-1:0]   upd_slot_q;
  logic [PARAM_W-1:0]  upd_param_q;

  int                  slot_i, param_i, entry_base, mask_base;
  logic                in_range;
  logic [DATA_W-1:0]   cur_entry, wr_masked;

  // Out-of-range selectors fold to offset 0 so no part-select leaves the bank.
  always_comb begin
    slot_i     = int'(bus.sel_slot);
    param_i    = int'(bus.sel_param);
    in_range   = (slot_i < NUM_SLOTS) && (param_i < NUM_PARAMS);
    entry_base = in_range ? (slot_i * NUM_PARAMS + param_i) * DATA_W : 0;
    mask_base  = in_range ? param_i * DATA_W : 0;
    cur_entry  = bank[entry_base +: DATA_W];
    wr_masked  = bus.wr_data & PARAM_MASK[mask_base +: DATA_W];
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
    cnt_next   = '0;
`endif
    case (state)
      IDLE: begin
        if (load_s) begin
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
          state_next = DEBOUNCE;
`else
          state_next = COMMIT;
`endif
        end
      end
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
      DEBOUNCE: begin
        if (!load_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_next = COMMIT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif
      COMMIT: begin
        commit     = 1'b1;
        state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!load_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 1'b0;
      load_s  <= 1'b0;
      state   <= IDLE;
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
      cnt     <= '0;
`endif
    end else begin
      sync_ff <= bus.load;
      load_s  <= sync_ff;
      state   <= state_next;
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
      cnt     <= cnt_next;
`endif
    end
  end

  // Reset dominates, so a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank        <= RESET_VALUES & FULL_MASK;
      rd_q        <= '0;
      upd_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      upd_slot_q  <= '0;
      upd_param_q <= '0;
    end else begin
      rd_q        <= in_range ? cur_entry : '0;
      upd_valid_q <= commit && in_range;
      addr_err_q  <= commit && !in_range;
      if (commit && in_range) begin
        bank[entry_base +: DATA_W] <= wr_masked;
        upd_slot_q                 <= bus.sel_slot;
        upd_param_q                <= bus.sel_param;
      end
    end
  end

  assign bus.param_bus = bank;
  assign bus.rd_data   = rd_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.upd_slot  = upd_slot_q;
  assign bus.upd_param = upd_param_q;

endmodule

// File: tb/tb_synth_param_bank.sv
// Directed bench for synth_param_bank: reset defaults, masked commits, held key,
// address errors, repeated writes and reset during COMMIT.
module tb_synth_param_bank;

  localparam int NS = 4;
  localparam int NP = 16;
  localparam int DW = 11;
  localparam int SW = 3;
  localparam int PW = 4;
  localparam int BW = NS * NP * DW;
  localparam int DEB = 8;
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
  localparam int LAT = 4 + DEB;
`else
  localparam int LAT = 4;
`endif

  function automatic logic [NP*DW-1:0] mk_mask();
    logic [NP*DW-1:0] m;
    m = '1;
    m[2*DW +: DW] = 11'h07F;
    m[3*DW +: DW] = 11'h0FF;
    return m;
  endfunction

  function automatic logic [BW-1:0] mk_reset();
    logic [BW-1:0] r;
    r = '0;
    r[(0*NP+2)*DW +: DW] = 11'h7FF;
    r[(1*NP+2)*DW +: DW] = 11'h07F;
    return r;
  endfunction

  localparam logic [NP*DW-1:0] MASK  = mk_mask();
  localparam logic [BW-1:0]    RVALS = mk_reset();

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  synth_param_bank_if #(.NUM_SLOTS(NS), .NUM_PARAMS(NP), .DATA_W(DW),
                        .SLOT_W(SW), .PARAM_W(PW)) bus ();

  synth_param_bank #(
    .NUM_SLOTS(NS), .NUM_PARAMS(NP), .DATA_W(DW), .SLOT_W(SW), .PARAM_W(PW),
    .PARAM_MASK(MASK), .RESET_VALUES(RVALS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] model;

  function automatic int base(int s, int p);
    return (s * NP + p) * DW;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    bus.load = 1'b0;
    repeat (4) tick();
  endtask

  task automatic reset_model();
    model = '0;
    model[base(0, 2) +: DW] = 11'h07F;
    model[base(1, 2) +: DW] = 11'h07F;
  endtask

  task automatic test_reset();
    bus.load = 1'b0;
    bus.sel_slot = '0;
    bus.sel_param = '0;
    bus.wr_data = '0;
    reset = 1'b1;
    tick();
    tick();
    reset_model();
    checks++;
    if (bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL reset_param_bus: got %h expected %h", bus.param_bus, model);
    end
    checks++;
    if ({bus.upd_valid, bus.addr_err} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 00", {bus.upd_valid, bus.addr_err});
    end
    checks++;
    if ({bus.rd_data, bus.upd_slot, bus.upd_param} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: rd=%h slot=%0d param=%0d expected all 0",
               bus.rd_data, bus.upd_slot, bus.upd_param);
    end
    bus.sel_slot = 3'd1;
    bus.sel_param = 4'd2;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.rd_data !== 11'h07F) begin
      errors++;
      $display("[TB] FAIL reset_readback: got %h expected 07f", bus.rd_data);
    end
  endtask

  task automatic test_write();
    bus.sel_slot = 3'd0;
    bus.sel_param = 4'd3;
    bus.wr_data = 11'h5A5;
    bus.load = 1'b1;
    repeat (LAT - 1) tick();
    checks++;
    if (bus.upd_valid !== 1'b0 || bus.param_bus[base(0, 3) +: DW] !== 11'h000) begin
      errors++;
      $display("[TB] FAIL write_early: upd_valid=%b entry=%h expected 0/000",
               bus.upd_valid, bus.param_bus[base(0, 3) +: DW]);
    end
    tick();
    model[base(0, 3) +: DW] = 11'h0A5;
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_slot !== 3'd0 || bus.upd_param !== 4'd3) begin
      errors++;
      $display("[TB] FAIL write_strobe: valid=%b slot=%0d param=%0d expected 1/0/3",
               bus.upd_valid, bus.upd_slot, bus.upd_param);
    end
    checks++;
    if (bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL write_bus: got %h expected %h", bus.param_bus, model);
    end
    bus.load = 1'b0;
    tick();
    checks++;
    if (bus.upd_valid !== 1'b0 || bus.rd_data !== 11'h0A5) begin
      errors++;
      $display("[TB] FAIL write_readback: valid=%b rd=%h expected 0/0a5",
               bus.upd_valid, bus.rd_data);
    end
    repeat (3) tick();
  endtask

  task automatic test_hold();
    int pulses;
    int first_idx;
    pulses = 0;
    first_idx = -1;
    bus.sel_slot = 3'd2;
    bus.sel_param = 4'd5;
    bus.load = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.wr_data = 11'(256 + i);
      tick();
      if (bus.upd_valid === 1'b1) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    model[base(2, 5) +: DW] = 11'(256 + LAT - 1);
    checks++;
    if (pulses !== 1 || first_idx !== LAT - 1) begin
      errors++;
      $display("[TB] FAIL hold_pulses: got %0d pulses at %0d expected 1 at %0d",
               pulses, first_idx, LAT - 1);
    end
    checks++;
    if (bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL hold_bus: got %h expected %h", bus.param_bus, model);
    end
    release_key();
    bus.wr_data = 11'h2AA;
    bus.load = 1'b1;
    repeat (LAT) tick();
    model[base(2, 5) +: DW] = 11'h2AA;
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL hold_second: valid=%b entry=%h expected 1/2aa",
               bus.upd_valid, bus.param_bus[base(2, 5) +: DW]);
    end
    release_key();
  endtask

  task automatic test_back_to_back();
    bus.wr_data = 11'h2AA;
    bus.load = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_value: valid=%b err=%b expected 1/0", bus.upd_valid, bus.addr_err);
    end
    tick();
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_value_width: got %b expected 0", bus.upd_valid);
    end
    release_key();
  endtask

  task automatic test_idle_noop();
    for (int i = 0; i < 6; i++) begin
      bus.sel_slot = 3'(i % 4);
      bus.sel_param = 4'(i * 3);
      bus.wr_data = 11'(11'h7FF - i);
      tick();
    end
    checks++;
    if (bus.param_bus !== model || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_noop: got %h expected %h", bus.param_bus, model);
    end
  endtask

  task automatic test_addr_err();
    bus.sel_slot = 3'd4;
    bus.sel_param = 4'd0;
    bus.wr_data = 11'h123;
    bus.load = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (bus.addr_err !== 1'b1 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addr_err_strobe: err=%b valid=%b expected 1/0", bus.addr_err, bus.upd_valid);
    end
    checks++;
    if (bus.param_bus !== model || bus.upd_slot !== 3'd2 || bus.upd_param !== 4'd5) begin
      errors++;
      $display("[TB] FAIL addr_err_hold: slot=%0d param=%0d expected 2/5 bus %h expected %h",
               bus.upd_slot, bus.upd_param, bus.param_bus, model);
    end
    tick();
    checks++;
    if (bus.addr_err !== 1'b0 || bus.rd_data !== 11'h000) begin
      errors++;
      $display("[TB] FAIL addr_err_after: err=%b rd=%h expected 0/000", bus.addr_err, bus.rd_data);
    end
    release_key();
  endtask

  task automatic test_reset_in_commit();
    bus.sel_slot = 3'd3;
    bus.sel_param = 4'd15;
    bus.wr_data = 11'h7FF;
    bus.load = 1'b1;
    repeat (LAT - 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_model();
    checks++;
    if (bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL rst_commit_bus: got %h expected %h", bus.param_bus, model);
    end
    checks++;
    if ({bus.upd_valid, bus.addr_err, bus.rd_data, bus.upd_slot, bus.upd_param} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_commit_regs: valid=%b err=%b rd=%h slot=%0d param=%0d expected all 0",
               bus.upd_valid, bus.addr_err, bus.rd_data, bus.upd_slot, bus.upd_param);
    end
    repeat (LAT) tick();
    model[base(3, 15) +: DW] = 11'h7FF;
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.param_bus !== model ||
        bus.upd_slot !== 3'd3 || bus.upd_param !== 4'd15) begin
      errors++;
      $display("[TB] FAIL rst_new_press: valid=%b slot=%0d param=%0d entry=%h expected 1/3/15/7ff",
               bus.upd_valid, bus.upd_slot, bus.upd_param, bus.param_bus[base(3, 15) +: DW]);
    end
    release_key();
  endtask

`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
  task automatic test_debounce();
    int pulses;
    int first_idx;
    pulses = 0;
    first_idx = -1;
    bus.sel_slot = 3'd1;
    bus.sel_param = 4'd7;
    bus.wr_data = 11'h333;
    for (int i = 1; i <= 25; i++) begin
      bus.load = (i <= 5);
      tick();
      if (bus.upd_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL debounce_short: got %0d pulses expected 0", pulses);
    end
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      bus.load = (i <= 12);
      tick();
      if (bus.upd_valid === 1'b1) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    model[base(1, 7) +: DW] = 11'h333;
    checks++;
    if (pulses !== 1 || first_idx !== 12 || bus.param_bus !== model) begin
      errors++;
      $display("[TB] FAIL debounce_long: got %0d pulses at %0d expected 1 at 12", pulses, first_idx);
    end
    release_key();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_hold();
    test_back_to_back();
    test_idle_noop();
    test_addr_err();
`ifdef SYNTH_PARAM_BANK_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_in_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
